// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg
//   Shared types and constants for the L1 -> MMU arbiter.
//   - LINE_W / ADDR_W : line and address widths of every MMU-side bus.
//   - arb_state_e     : arbiter FSM state (2-bit encoding).
//   - owner_e         : which L1 cache owns (or last won) the MMU port.
//   - rr_pick()       : round-robin tie-break; the requester that did not win last.
package l1_arb_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_IC = 2'd1,
    ST_GRANT_DC = 2'd2,
    ST_DRAIN    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_e;

  function automatic owner_e rr_pick(input owner_e last_owner);
    return (last_owner == OWNER_IC) ? OWNER_DC : OWNER_IC;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog
//   Grant-duration watchdog for the MMU arbiter. Counts cycles spent in a
//   grant state and raises a sticky timeout flag once a single grant has
//   lasted TIMEOUT_CYCLES cycles. The counter saturates instead of wrapping.
// Ports:
//   sys_clk  : clock
//   rst      : synchronous active-high reset (clears counter and flag)
//   clear    : restart the count (asserted on the cycle before a grant begins)
//   count_en : high during every grant cycle
//   timeout  : sticky; high from the TIMEOUT_CYCLES-th grant cycle until rst
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic             flag_q;
  logic             at_limit;

  // The first grant cycle sees count 0, so the count equals the limit on the
  // TIMEOUT_CYCLES-th grant cycle; the flag is raised combinationally there
  // and the register keeps it afterwards. '>=' covers the saturated region.
  assign at_limit = count_en && (count_q >= CNT_LIMIT);
  assign timeout  = flag_q | at_limit;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would create order-dependent simulation.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      if (clear) begin
        count_q <= '0;
      end else if (count_en && (count_q != CNT_MAX)) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (at_limit) begin
        flag_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter
//   Shares the single MMU line-transfer port between the L1 icache and
//   dcache. Round-robin grant on ties, grant held until mmu_done, one DRAIN
//   cycle after every completion so a stale request level is never re-issued,
//   and a sticky watchdog flag for over-long grants.
// Ports:
//   sys_clk, rst                      : clock, synchronous active-high reset
//   ic_mmu_req_read/addr              : icache line read request (level)
//   ic_mmu_done, ic_mmu_read_data     : completion pulse / data to icache
//   dc_mmu_req_read/write/addr/write_data : dcache request (level)
//   dc_mmu_done, dc_mmu_read_data     : completion pulse / data to dcache
//   mmu_req_read/write/addr/write_data: request towards the MMU
//   mmu_done, mmu_read_data           : MMU completion pulse and read data
//   arb_timeout                       : sticky grant-timeout flag
module l1_mmu_arbiter
  import l1_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ic_mmu_req_read,
  input  logic [ADDR_W-1:0] ic_mmu_req_addr,
  output logic              ic_mmu_done,
  output logic [LINE_W-1:0] ic_mmu_read_data,
  input  logic              dc_mmu_req_read,
  input  logic              dc_mmu_req_write,
  input  logic [ADDR_W-1:0] dc_mmu_req_addr,
  input  logic [LINE_W-1:0] dc_mmu_write_data,
  output logic              dc_mmu_done,
  output logic [LINE_W-1:0] dc_mmu_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              arb_timeout
);

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  owner_e     tie_winner;
  logic       ic_pend, dc_pend;
  logic       wd_clear, wd_count_en;

  assign ic_pend    = ic_mmu_req_read;
  assign dc_pend    = dc_mmu_req_read | dc_mmu_req_write;
  assign tie_winner = rr_pick(last_owner_q);

  // Read data goes to both caches unconditionally; only the owner's done
  // pulse tells a cache that the bus carries its data.
  assign ic_mmu_read_data = mmu_read_data;
  assign dc_mmu_read_data = mmu_read_data;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_IC;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    mmu_req_read   = 1'b0;
    mmu_req_write  = 1'b0;
    mmu_req_addr   = '0;
    mmu_write_data = '0;
    ic_mmu_done    = 1'b0;
    dc_mmu_done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ic_pend && dc_pend) begin
          last_owner_d = tie_winner;
          state_d      = (tie_winner == OWNER_DC) ? ST_GRANT_DC : ST_GRANT_IC;
        end else if (ic_pend) begin
          state_d = ST_GRANT_IC;
        end else if (dc_pend) begin
          state_d = ST_GRANT_DC;
        end
      end

      ST_GRANT_IC: begin
        mmu_req_read = ic_mmu_req_read;
        mmu_req_addr = ic_mmu_req_addr;
        ic_mmu_done  = mmu_done;
        // Done wins over a simultaneous request drop.
        if (mmu_done) begin
          state_d = ST_DRAIN;
        end else if (!ic_pend) begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT_DC: begin
        mmu_req_read   = dc_mmu_req_read;
        mmu_req_write  = dc_mmu_req_write;
        mmu_req_addr   = dc_mmu_req_addr;
        mmu_write_data = dc_mmu_write_data;
        dc_mmu_done    = mmu_done;
        if (mmu_done) begin
          state_d = ST_DRAIN;
        end else if (!dc_pend) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // The just-completed cache may still hold its request this cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset drops the MMU request and swallows any in-flight done in the
    // same cycle rather than waiting for the state register to clear.
    if (rst) begin
      mmu_req_read   = 1'b0;
      mmu_req_write  = 1'b0;
      mmu_req_addr   = '0;
      mmu_write_data = '0;
      ic_mmu_done    = 1'b0;
      dc_mmu_done    = 1'b0;
    end
  end

  assign wd_count_en = (state_q == ST_GRANT_IC) || (state_q == ST_GRANT_DC);
  assign wd_clear    = (state_q == ST_IDLE) &&
                       ((state_d == ST_GRANT_IC) || (state_d == ST_GRANT_DC));

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .timeout  (arb_timeout)
  );

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
`timescale 1ns/1ps
// tb_l1_mmu_arbiter
//   Scoreboarded bench: each round of cache requests is turned into an
//   expected sequence of MMU transactions by a transaction-level round-robin
//   model; a monitor compares every MMU request and every done pulse against
//   the queues. Short directed sequences cover abort, watchdog and reset.
module tb_l1_mmu_arbiter;
  import l1_arb_pkg::*;

  localparam int TO = 16;

  logic              sys_clk, rst;
  logic              ic_mmu_req_read;
  logic [ADDR_W-1:0] ic_mmu_req_addr;
  logic              ic_mmu_done;
  logic [LINE_W-1:0] ic_mmu_read_data;
  logic              dc_mmu_req_read, dc_mmu_req_write;
  logic [ADDR_W-1:0] dc_mmu_req_addr;
  logic [LINE_W-1:0] dc_mmu_write_data;
  logic              dc_mmu_done;
  logic [LINE_W-1:0] dc_mmu_read_data;
  logic              mmu_req_read, mmu_req_write;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;
  logic              arb_timeout;

  l1_mmu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .ic_mmu_req_read   (ic_mmu_req_read),
    .ic_mmu_req_addr   (ic_mmu_req_addr),
    .ic_mmu_done       (ic_mmu_done),
    .ic_mmu_read_data  (ic_mmu_read_data),
    .dc_mmu_req_read   (dc_mmu_req_read),
    .dc_mmu_req_write  (dc_mmu_req_write),
    .dc_mmu_req_addr   (dc_mmu_req_addr),
    .dc_mmu_write_data (dc_mmu_write_data),
    .dc_mmu_done       (dc_mmu_done),
    .dc_mmu_read_data  (dc_mmu_read_data),
    .mmu_req_read      (mmu_req_read),
    .mmu_req_write     (mmu_req_write),
    .mmu_req_addr      (mmu_req_addr),
    .mmu_write_data    (mmu_write_data),
    .mmu_done          (mmu_done),
    .mmu_read_data     (mmu_read_data),
    .arb_timeout       (arb_timeout)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit                is_dc;
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } op_t;

  typedef struct {
    op_t op;
    bit  first;
  } exp_req_t;

  op_t               ic_q[$], dc_q[$];
  exp_req_t          exp_req_q[$];
  logic [LINE_W-1:0] exp_done_q[$];

  bit mdl_last_dc;        // model: last tie winner was the dcache
  bit mon_en;
  bit cur_is_dc;
  bit prev_req;
  int first_cycle, last_done_cycle;
  bit rsp_busy;
  int rsp_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    bit                req_now;
    exp_req_t          e;
    logic [LINE_W-1:0] d;
    req_now = mmu_req_read | mmu_req_write;
    if (mon_en) begin
      if (req_now && !prev_req) begin
        if (exp_req_q.size() == 0) begin
          check("req_unexpected", req_now, 1'b0);
        end else begin
          e = exp_req_q.pop_front();
          check("req_read",  mmu_req_read,   e.op.rd);
          check("req_write", mmu_req_write,  e.op.wr);
          check("req_addr",  mmu_req_addr,   e.op.addr);
          check("req_wdata", mmu_write_data, e.op.wdata);
          check("req_start_cycle", cyc, e.first ? first_cycle + 1 : last_done_cycle + 3);
          cur_is_dc = e.op.is_dc;
        end
      end
      if (ic_mmu_done || dc_mmu_done) begin
        if (exp_done_q.size() == 0) begin
          check("done_unexpected", ic_mmu_done | dc_mmu_done, 1'b0);
        end else begin
          d = exp_done_q.pop_front();
          check("ic_done", ic_mmu_done, !cur_is_dc);
          check("dc_done", dc_mmu_done, cur_is_dc);
          check("done_data", cur_is_dc ? dc_mmu_read_data : ic_mmu_read_data, d);
          last_done_cycle = cyc;
        end
      end
    end
    prev_req = req_now;
  end

  // ---------------- reference model ----------------
  // Each cache serves its own list in order; a tie goes to the cache that did
  // not win the previous tie, otherwise the only pending cache is served.
  task automatic model_round();
    op_t      a[$], b[$];
    exp_req_t e;
    bit       pick_dc;
    int       k;
    a = ic_q;
    b = dc_q;
    k = 0;
    while (a.size() != 0 || b.size() != 0) begin
      if (a.size() != 0 && b.size() != 0) begin
        pick_dc     = !mdl_last_dc;
        mdl_last_dc = pick_dc;
      end else begin
        pick_dc = (b.size() != 0);
      end
      e.op    = pick_dc ? b.pop_front() : a.pop_front();
      e.first = (k == 0);
      exp_req_q.push_back(e);
      k++;
    end
  endtask

  task automatic apply_caches();
    ic_mmu_req_read   = (ic_q.size() != 0) ? ic_q[0].rd : 1'b0;
    ic_mmu_req_addr   = (ic_q.size() != 0) ? ic_q[0].addr : '0;
    dc_mmu_req_read   = (dc_q.size() != 0) ? dc_q[0].rd : 1'b0;
    dc_mmu_req_write  = (dc_q.size() != 0) ? dc_q[0].wr : 1'b0;
    dc_mmu_req_addr   = (dc_q.size() != 0) ? dc_q[0].addr : '0;
    dc_mmu_write_data = (dc_q.size() != 0) ? dc_q[0].wdata : '0;
  endtask

  // Present ic_q/dc_q (arbiter must be idle), play the MMU, advance each
  // cache on its done. fixed_delay < 0 selects a random MMU latency.
  task automatic run_round(input int fixed_delay, input bit fixed_data_en,
                           input logic [LINE_W-1:0] fixed_data);
    int budget;
    bit icd, dcd;
    model_round();
    first_cycle = cyc;
    apply_caches();
    rsp_busy = 1'b0;
    budget   = 0;
    while ((ic_q.size() != 0 || dc_q.size() != 0 || rsp_busy) && budget < 400) begin
      @(negedge sys_clk);
      icd = ic_mmu_done;
      dcd = dc_mmu_done;
      tick();
      if (icd && ic_q.size() != 0) void'(ic_q.pop_front());
      if (dcd && dc_q.size() != 0) void'(dc_q.pop_front());
      apply_caches();
      mmu_done      = 1'b0;
      mmu_read_data = rand_line();
      if (!rsp_busy && (mmu_req_read || mmu_req_write)) begin
        rsp_busy = 1'b1;
        rsp_cnt  = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 5);
      end
      if (rsp_busy) begin
        if (rsp_cnt == 0) begin
          mmu_done      = 1'b1;
          mmu_read_data = fixed_data_en ? fixed_data : rand_line();
          exp_done_q.push_back(mmu_read_data);
          rsp_busy      = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
      budget++;
    end
    check("round_completed", budget < 400, 1'b1);
    ic_q.delete();
    dc_q.delete();
    apply_caches();
    mmu_done = 1'b0;
    repeat (2 + $urandom_range(0, 2)) tick();
    check("exp_req_drained",  exp_req_q.size(),  0);
    check("exp_done_drained", exp_done_q.size(), 0);
    check("no_timeout", arb_timeout, 1'b0);
    exp_req_q.delete();
    exp_done_q.delete();
  endtask

  function automatic op_t mk_ic(input logic [ADDR_W-1:0] addr);
    op_t o;
    o.is_dc = 1'b0; o.rd = 1'b1; o.wr = 1'b0; o.addr = addr; o.wdata = '0;
    return o;
  endfunction

  function automatic op_t mk_dc(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                                input logic [LINE_W-1:0] wdata);
    op_t o;
    o.is_dc = 1'b1; o.rd = rd; o.wr = wr; o.addr = addr; o.wdata = wdata;
    return o;
  endfunction

  task automatic do_reset();
    rst               = 1'b1;
    ic_q.delete();
    dc_q.delete();
    apply_caches();
    mmu_done          = 1'b0;
    mmu_read_data     = '0;
    repeat (2) tick();
    rst               = 1'b0;
    mdl_last_dc       = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int n_ic, n_dc, kind;
    mon_en = 1'b0;
    do_reset();

    @(negedge sys_clk);
    check("rst_req_read",  mmu_req_read,   1'b0);
    check("rst_req_write", mmu_req_write,  1'b0);
    check("rst_addr",      mmu_req_addr,   '0);
    check("rst_wdata",     mmu_write_data, '0);
    check("rst_ic_done",   ic_mmu_done,    1'b0);
    check("rst_dc_done",   dc_mmu_done,    1'b0);
    check("rst_timeout",   arb_timeout,    1'b0);
    tick();

    mon_en = 1'b1;

    // Single icache read, MMU answers 5 cycles later with 0xA5..A5.
    ic_q.push_back(mk_ic(32'h0000_1000));
    run_round(5, 1'b1, {32{8'hA5}});

    // Repeated ties alternate the owner, starting with the dcache.
    for (int r = 0; r < 4; r++) begin
      ic_q.push_back(mk_ic(32'h0001_0000 + 32'(r) * 32'h40));
      dc_q.push_back(mk_dc(1'b1, 1'b0, 32'h0002_0000 + 32'(r) * 32'h40, '0));
      run_round(-1, 1'b0, '0);
    end

    // Dirty flush then refill with an icache request pending.
    dc_q.push_back(mk_dc(1'b0, 1'b1, 32'h0040_0000, rand_line()));
    dc_q.push_back(mk_dc(1'b1, 1'b0, 32'h0080_0000, '0));
    ic_q.push_back(mk_ic(32'h0000_3000));
    run_round(-1, 1'b0, '0);

    // Random traffic.
    for (int r = 0; r < 40; r++) begin
      n_ic = $urandom_range(0, 2);
      n_dc = $urandom_range(0, 2);
      if (n_ic == 0 && n_dc == 0) n_ic = 1;
      for (int i = 0; i < n_ic; i++) ic_q.push_back(mk_ic($urandom & 32'hFFFF_FFE0));
      for (int i = 0; i < n_dc; i++) begin
        kind = $urandom_range(0, 2);
        dc_q.push_back(mk_dc(kind != 1, kind != 0, $urandom & 32'hFFFF_FFE0, rand_line()));
      end
      run_round(-1, 1'b0, '0);
    end

    mon_en = 1'b0;

    // Abort: icache drops mid-grant, dcache then granted; stray done in IDLE.
    do_reset();
    ic_mmu_req_read = 1'b1; ic_mmu_req_addr = 32'h0000_2040;         // c0
    tick();
    dc_mmu_req_read = 1'b1; dc_mmu_req_addr = 32'h0000_3000;         // c1
    @(negedge sys_clk);
    check("abort_ic_granted", mmu_req_read, 1'b1);
    check("abort_ic_addr", mmu_req_addr, 32'h0000_2040);
    tick(); ic_mmu_req_read = 1'b0;                                   // c2
    @(negedge sys_clk);
    check("abort_req_dropped", mmu_req_read, 1'b0);
    check("abort_no_ic_done", ic_mmu_done, 1'b0);
    tick(); mmu_done = 1'b1;                                          // c3 IDLE
    @(negedge sys_clk);
    check("idle_done_ignored_ic", ic_mmu_done, 1'b0);
    check("idle_done_ignored_dc", dc_mmu_done, 1'b0);
    check("idle_no_req", mmu_req_read, 1'b0);
    tick(); mmu_done = 1'b0;                                          // c4 GRANT_DC
    @(negedge sys_clk);
    check("abort_dc_granted", mmu_req_read, 1'b1);
    check("abort_dc_addr", mmu_req_addr, 32'h0000_3000);
    tick(); mmu_done = 1'b1; mmu_read_data = {8{32'hC0FFEE11}};       // c5
    @(negedge sys_clk);
    check("dc_done_pulse", dc_mmu_done, 1'b1);
    check("dc_done_not_ic", ic_mmu_done, 1'b0);
    check("dc_done_data", dc_mmu_read_data, {8{32'hC0FFEE11}});
    tick(); mmu_done = 1'b0;                                          // c6 DRAIN, stale level
    @(negedge sys_clk);
    check("drain_masks_req", mmu_req_read, 1'b0);
    check("drain_no_done", dc_mmu_done, 1'b0);
    tick(); dc_mmu_req_read = 1'b0;                                   // c7

    // Watchdog: MMU never answers.
    do_reset();
    dc_mmu_req_read = 1'b1; dc_mmu_req_addr = 32'h0000_5000;         // c0
    for (int g = 1; g <= 20; g++) begin
      tick();
      @(negedge sys_clk);
      if (g == TO - 1) check("timeout_not_yet", arb_timeout, 1'b0);
      if (g == TO)     check("timeout_set", arb_timeout, 1'b1);
      if (g == 20) begin
        check("timeout_sticky", arb_timeout, 1'b1);
        check("timeout_grant_kept", mmu_req_read, 1'b1);
      end
    end
    tick(); rst = 1'b1;                                               // c21
    tick(); rst = 1'b0;                                               // c22
    @(negedge sys_clk);
    check("timeout_cleared", arb_timeout, 1'b0);
    check("timeout_rst_idle", mmu_req_read, 1'b0);
    tick();                                                           // c23
    @(negedge sys_clk);
    check("regrant_after_rst", mmu_req_read, 1'b1);
    check("regrant_no_timeout", arb_timeout, 1'b0);

    // Reset during GRANT_DC, then a late mmu_done.
    do_reset();
    dc_mmu_req_write = 1'b1; dc_mmu_req_addr = 32'h0040_0000;
    dc_mmu_write_data = {8{32'h1234_5678}};                           // c0
    tick(); tick();                                                   // c2
    @(negedge sys_clk);
    check("rstgrant_write", mmu_req_write, 1'b1);
    tick(); rst = 1'b1;                                               // c3
    tick(); rst = 1'b0; mmu_done = 1'b1;                              // c4
    @(negedge sys_clk);
    check("rstgrant_no_dc_done", dc_mmu_done, 1'b0);
    check("rstgrant_no_ic_done", ic_mmu_done, 1'b0);
    check("rstgrant_write_low", mmu_req_write, 1'b0);
    check("rstgrant_read_low", mmu_req_read, 1'b0);
    check("rstgrant_addr_zero", mmu_req_addr, '0);
    check("rstgrant_wdata_zero", mmu_write_data, '0);
    check("rstgrant_timeout", arb_timeout, 1'b0);
    tick(); mmu_done = 1'b0; dc_mmu_req_write = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_mmu_arbiter.md
# l1_mmu_arbiter

Shares the single MMU line-transfer port between the L1 instruction cache and the L1 data cache. The block sits between both L1 caches and the MMU and owns the request/done handshake on each side. It grants one requester at a time with round-robin priority and holds the grant until the MMU completes. It also inserts a drain cycle after every completion so a stale request level is never re-issued, and it flags MMU transactions that exceed a cycle budget.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: cycles in a grant state before `arb_timeout` sets.

Ports:
- `sys_clk`  in  1  clock; single clock domain, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `ic_mmu_req_read`  in  1  icache line read request; level-held until done.
- `ic_mmu_req_addr`  in  32  icache request address.
- `ic_mmu_done`  out  1  one-cycle completion pulse to icache.
- `ic_mmu_read_data`  out  256  line data to icache.
- `dc_mmu_req_read`  in  1  dcache read request (line or MMIO).
- `dc_mmu_req_write`  in  1  dcache write request (dirty flush, write-through or MMIO).
- `dc_mmu_req_addr`  in  32  dcache request address.
- `dc_mmu_write_data`  in  256  dcache write data.
- `dc_mmu_done`  out  1  one-cycle completion pulse to dcache.
- `dc_mmu_read_data`  out  256  read data to dcache.
- `mmu_req_read`, `mmu_req_write`  out  1  request to MMU.
- `mmu_req_addr`  out  32  address to MMU.
- `mmu_write_data`  out  256  write data to MMU.
- `mmu_done`  in  1  MMU completion pulse.
- `mmu_read_data`  in  256  MMU read data; valid while `mmu_done`=1.
- `arb_timeout`  out  1  sticky flag: a grant exceeded `TIMEOUT_CYCLES`.

## Operation
- States: IDLE, GRANT_IC, GRANT_DC, DRAIN.
- Pending signals:
  - `ic_pend` = `ic_mmu_req_read`.
  - `dc_pend` = `dc_mmu_req_read | dc_mmu_req_write`.
- IDLE:
  - Only `ic_pend`: go to GRANT_IC.
  - Only `dc_pend`: go to GRANT_DC.
  - Both pending: grant the requester that is not `last_owner`, then update `last_owner`.
  - `last_owner` resets to IC, so the first tie goes to DC.
- GRANT_x:
  - MMU outputs combinationally mirror the owner's live request, addr and write data.
  - For the icache, `mmu_req_write`=0 and `mmu_write_data`=0.
  - `dc_mmu_req_read` and `dc_mmu_req_write` pass through unchanged, even when both are set.
  - A dcache flush-then-refill sequence arrives as two separate requests; each is arbitrated independently.
- Completion:
  - `mmu_done` is forwarded as `x_mmu_done` to the owner only, in the same cycle.
  - `mmu_read_data` is routed to both read-data outputs at all times; only the owner's done qualifies it.
  - Next state is DRAIN.
- Abort: if the owner's pend drops in GRANT_x without `mmu_done`, return to IDLE next cycle. The MMU sees the request drop as a cancel.
- DRAIN: lasts one cycle; all MMU outputs are 0, no done is forwarded, and the next state is IDLE.
- Non-owners never receive done. Their requests stay pending until granted.
- Watchdog:
  - The counter clears on entry to GRANT_x and increments each cycle in GRANT_x.
  - When the count reaches `TIMEOUT_CYCLES - 1`, `arb_timeout` sets.
  - The flag holds until `rst`; the grant is unaffected.
  - The counter saturates and does not wrap.
  - Counter width is clog2(`TIMEOUT_CYCLES`) + 1.

## Timing
- Reset values:
  - State = IDLE, `last_owner` = IC, counter = 0.
  - `arb_timeout`, all `mmu_*` outputs and both done outputs are 0.
- `rst` mid-grant forces IDLE on the next edge. The MMU request drops in that same cycle; any in-flight MMU done is ignored.
- Grant latency: pend sampled in IDLE at cycle 0; the MMU request is visible in cycle 1.
- Done path is zero-latency (combinational) from `mmu_done` to `x_mmu_done`.
- Back-to-back sequence:
  - `mmu_done` at cycle N.
  - DRAIN at N+1.
  - IDLE arbitrates at N+2.
  - Next MMU request at N+3.
- `mmu_done` outside GRANT_x is ignored.
- `mmu_done` coinciding with the owner dropping its request counts as completion: done is forwarded and the next state is DRAIN.

## Structure
- Package `l1_arb_pkg`:
  - State encoding: 2 bits.
  - Owner encoding: IC=0, DC=1.
  - `LINE_W`=256 and `ADDR_W`=32.
- Sub-module `arb_watchdog`, owning the saturating counter and the sticky flag:
  - Inputs: `clear`, `count_en`.
  - Output: `timeout`.
- Arbiter FSM, round-robin pick and output muxes live in the top level.

## Test plan
- Single icache read at addr 0x0000_1000; MMU done 5 cycles later → `mmu_req_read` rises 1 cycle after the request; `ic_mmu_done` pulses for exactly one cycle with data 0xA5…A5; DRAIN follows.
- Simultaneous ic and dc reads after reset → DC granted first, then IC granted at done+3. Repeating the tie alternates the owner each time.
- Dcache dirty flush (write, addr 0x0040_0000) followed by refill read (addr 0x0080_0000), while an icache request is pending → order is DC write, IC read, DC read, showing round-robin between dcache phases.
- Owner drops its request mid-grant without done → state returns to IDLE next cycle, no done is generated, and the other requester is granted 1 cycle later.
- MMU never answers with `TIMEOUT_CYCLES`=16 → `arb_timeout`=1 at the 16th grant cycle and stays 1; `rst` clears it and state returns to IDLE.
- `rst` asserted during GRANT_DC → all outputs are 0 on the next cycle. A late `mmu_done` then produces no `dc_mmu_done`.
